grid_walker_param: RTL and testbench
====================================

Name: grid_walker_param

Overview:
Parametrised grid walker. Holds an (x,y) position on a 2^COORD_W x 2^COORD_W grid and executes direction+step-count commands one unit step per clock. Commands arrive over a valid/ready handshake. The block reports completion and boundary events, and mirrors the position onto the board LED bus. Sits between the switch/command decoder and the LED bank; it is the multi-cycle, selectable-edge-mode successor to the single-shot walker.

Parameters:
COORD_W, 4, width of each coordinate (grid side = 2^COORD_W)
STEP_W, 2, width of step-count field; max steps per command = 2^STEP_W-1

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command
cmd_dir  input  2  00 +x, 01 -x, 10 +y, 11 -y
cmd_steps  input  STEP_W  unit steps to take
wrap_en  input  1  1 = modular wrap at edges, 0 = saturate at edges; sampled at accept
busy  output  1  command in progress
done  output  1  one-cycle pulse at command completion
bound_hit  output  1  valid with done: at least one step of this command was blocked (saturate mode only)
pos_x  output  COORD_W  current x
pos_y  output  COORD_W  current y
led  output  2*COORD_W  {pos_y, pos_x}
odometer  output  16  total unit moves taken (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state IDLE; pos_x=0, pos_y=0, led=0; cmd_ready=1; busy=0; done=0; bound_hit=0; odometer=0. Reset mid-command aborts it; no done pulse is issued.
- FSM states IDLE, MOVE, DONE.
- IDLE: cmd_ready=1, busy=0. On rising edge with cmd_valid=1, latch dir, steps, wrap_en, and clear the internal blocked flag.
  - steps==0: go to DONE.
  - Otherwise: load remaining=steps and go to MOVE.
- MOVE: cmd_ready=0, busy=1. Each edge:
  - Apply one unit step on the axis selected by dir[1], with sign from dir[0] (0 = increment).
  - Decrement remaining. When remaining reaches 0 after the step, go to DONE.
- DONE: cmd_ready=0, busy=1. done=1 and bound_hit=blocked for exactly this cycle. Next edge returns to IDLE.
- Latency: command accepted at edge k with N>0 steps:
  - Position updates at edges k+1..k+N.
  - done is high during the cycle after edge k+N.
  - cmd_ready returns high after edge k+N+1.
  - N=0: done is high the cycle after edge k, and position is unchanged.
- Wrap mode: arithmetic is modulo 2^COORD_W. Incrementing max goes to 0; decrementing 0 goes to max. blocked stays 0.
- Saturate mode: a step that would leave the grid leaves the coordinate unchanged and sets blocked. The remaining count still decrements, so the command takes a fixed N cycles regardless of blocking.
- Only the selected axis changes; the other axis holds.
- cmd_valid while not in IDLE is ignored (no queuing). The source must hold cmd_valid until it sees cmd_ready.
- led is a pure function of pos registers: it updates on the same edge as pos_x/pos_y, with no extra latency.
- done and bound_hit are 0 in all states except DONE.

Optional Feature:
GRID_WALKER_ODOMETER_EN
- Defined: odometer is a 16-bit register, reset 0. It increments on every MOVE edge where the position actually changed; blocked steps do not count. It saturates at 16'hFFFF.
- Undefined: odometer is tied to 0; the port is still present.

Test Plan:
- Reset, then cmd dir=00 steps=3 wrap_en=0 -> pos_x 1,2,3 on three successive edges; done one cycle later; bound_hit=0; led=8'h03; cmd_ready back after one more edge.
- From (0,0), dir=01 steps=2 wrap_en=0 -> pos_x stays 0; done with bound_hit=1; busy exactly 3 cycles; odometer unchanged (macro on).
- From (0,0), dir=11 steps=2 wrap_en=1 -> pos_y 15 then 14; bound_hit=0; led=8'hE0; odometer +2 (macro on), 0 (macro off).
- steps=0 with dir=10 -> done on the cycle after accept; position unchanged; cmd_ready high again one edge later.
- cmd_valid held high during MOVE with a different command -> ignored until IDLE; the second command is then accepted exactly once on the first IDLE edge.
- Assert rst_n=0 asynchronously mid-MOVE at (2,0) -> outputs go to reset values immediately without a clock edge; no done pulse follows release.

Source files
------------

// File: rtl/grid_walker_param_if.sv
// grid_walker_param_if
// Command channel for grid_walker_param.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both 1. The source holds cmd_valid, cmd_dir, cmd_steps and
// wrap_en stable until that edge. cmd_ready does not depend on cmd_valid.
//
// Signals:
//   cmd_valid  source -> walker  command present
//   cmd_ready  walker -> source  walker is idle and will take a command
//   cmd_dir    source -> walker  00 +x, 01 -x, 10 +y, 11 -y
//   cmd_steps  source -> walker  unit steps to take (0 allowed)
//   wrap_en    source -> walker  1 = wrap at edges, 0 = saturate
interface grid_walker_param_if #(
  parameter int STEP_W = 2
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_dir;
  logic [STEP_W-1:0] cmd_steps;
  logic              wrap_en;

  modport master (
    output cmd_valid,
    output cmd_dir,
    output cmd_steps,
    output wrap_en,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_dir,
    input  cmd_steps,
    input  wrap_en,
    output cmd_ready
  );
endinterface

// File: rtl/grid_walker_param.sv
// grid_walker_param
// Holds an (x,y) position on a 2^COORD_W square grid and executes
// direction + step-count commands, one unit step per clock.
//
// Optional feature macro: GRID_WALKER_ODOMETER_EN
//   defined   -> odometer counts real position changes, saturating at 16'hFFFF
//   undefined -> odometer is tied to 0
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   cmd        command channel (grid_walker_param_if.slave)
//   busy       command in progress (MOVE or DONE)
//   done       one-cycle completion pulse (DONE state)
//   bound_hit  with done: some step of this command was blocked at an edge
//   pos_x      current x
//   pos_y      current y
//   led        {pos_y, pos_x}
//   odometer   total unit moves taken
//   state_dbg  FSM state encoding (0 IDLE, 1 MOVE, 2 DONE)
module grid_walker_param #(
  parameter int COORD_W = 4,
  parameter int STEP_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  grid_walker_param_if.slave   cmd,
  output logic                 busy,
  output logic                 done,
  output logic                 bound_hit,
  output logic [COORD_W-1:0]   pos_x,
  output logic [COORD_W-1:0]   pos_y,
  output logic [2*COORD_W-1:0] led,
  output logic [15:0]          odometer,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [COORD_W-1:0] COORD_MAX = '1;
  localparam logic [COORD_W-1:0] COORD_ONE = COORD_W'(1);
  localparam logic [STEP_W-1:0]  STEP_ONE  = STEP_W'(1);

  state_t              state, next_state;
  logic [1:0]          dir_q;
  logic [STEP_W-1:0]   rem_q;
  logic                wrap_q;
  logic                blocked_q;

  logic [COORD_W-1:0]  cur_c;
  logic [COORD_W-1:0]  next_c;
  logic                at_edge;
  logic                step_blocked;
  logic                accept;

  assign accept = (state == S_IDLE) && cmd.cmd_valid;

  // Step datapath: pick the axis from dir[1], direction from dir[0].
  // Plain modular add/subtract gives wrap behaviour for free; saturate mode
  // only has to suppress the update when the coordinate sits on the edge.
  always_comb begin
    cur_c        = dir_q[1] ? pos_y : pos_x;
    at_edge      = dir_q[0] ? (cur_c == '0) : (cur_c == COORD_MAX);
    step_blocked = at_edge && !wrap_q;
    next_c       = dir_q[0] ? (cur_c - COORD_ONE) : (cur_c + COORD_ONE);
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (cmd.cmd_valid) next_state = (cmd.cmd_steps == '0) ? S_DONE : S_MOVE;
      S_MOVE: if (rem_q == STEP_ONE) next_state = S_DONE;
      S_DONE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q     <= '0;
      rem_q     <= '0;
      wrap_q    <= 1'b0;
      blocked_q <= 1'b0;
      pos_x     <= '0;
      pos_y     <= '0;
    end else if (accept) begin
      dir_q     <= cmd.cmd_dir;
      rem_q     <= cmd.cmd_steps;
      wrap_q    <= cmd.wrap_en;
      blocked_q <= 1'b0;
    end else if (state == S_MOVE) begin
      // The count decrements even on a blocked step so duration is fixed.
      rem_q <= rem_q - STEP_ONE;
      if (step_blocked) begin
        blocked_q <= 1'b1;
      end else if (dir_q[1]) begin
        pos_y <= next_c;
      end else begin
        pos_x <= next_c;
      end
    end
  end

`ifdef GRID_WALKER_ODOMETER_EN
  logic [15:0] odo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      odo_q <= '0;
    end else if ((state == S_MOVE) && !step_blocked && (odo_q != 16'hFFFF)) begin
      odo_q <= odo_q + 16'd1;
    end
  end

  assign odometer = odo_q;
`else
  assign odometer = '0;
`endif

  assign cmd.cmd_ready = (state == S_IDLE);
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);
  assign bound_hit     = (state == S_DONE) && blocked_q;
  assign led           = {pos_y, pos_x};
  assign state_dbg     = state;

endmodule

// File: tb/tb_grid_walker_param.sv
// tb_grid_walker_param
// Directed bench for grid_walker_param. The driver pushes the expected
// completion response {bound_hit, led, odometer} when it issues a command;
// the monitor pops and compares whenever done is presented.
module tb_grid_walker_param;

  localparam int COORD_W = 4;
  localparam int STEP_W  = 2;
  localparam int RESP_W  = 1 + 2*COORD_W + 16;

  logic                 clk;
  logic                 rst_n;
  logic                 busy;
  logic                 done;
  logic                 bound_hit;
  logic [COORD_W-1:0]   pos_x;
  logic [COORD_W-1:0]   pos_y;
  logic [2*COORD_W-1:0] led;
  logic [15:0]          odometer;
  logic [1:0]           state_dbg;

  grid_walker_param_if #(.STEP_W(STEP_W)) cmd_if ();

  grid_walker_param #(.COORD_W(COORD_W), .STEP_W(STEP_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd       (cmd_if),
    .busy      (busy),
    .done      (done),
    .bound_hit (bound_hit),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .led       (led),
    .odometer  (odometer),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected end of test");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [RESP_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] odo(input int v);
`ifdef GRID_WALKER_ODOMETER_EN
    return 16'(v);
`else
    return (v == 0) ? 16'd0 : 16'd0;
`endif
  endfunction

  // Monitor: compares the completion response whenever done is presented.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL done_unexpected: got done=1, expected no completion at %0t", $time);
      end else begin
        logic [RESP_W-1:0] e;
        e = exp_q.pop_front();
        check("done_resp", 32'({bound_hit, led, odometer}), 32'(e));
        check("done_pos", 32'({pos_y, pos_x}), 32'(e[23:16]));
      end
    end else if (bound_hit) begin
      check("bound_hit_outside_done", 32'(bound_hit), 32'd0);
    end
  end

  // ---------------- driver ----------------
  // Issues one command and checks led after each step edge, the busy
  // window and the return of cmd_ready one edge after done.
  task automatic run_cmd(input logic [1:0] dir, input int steps, input logic wrap,
                         input logic bh, input logic [7:0] t0, input logic [7:0] t1,
                         input logic [7:0] t2, input logic [7:0] fin, input logic [15:0] o);
    logic [7:0] traj [3];
    traj[0] = t0; traj[1] = t1; traj[2] = t2;
    @(negedge clk);
    check("ready_before_cmd", 32'(cmd_if.cmd_ready), 32'd1);
    exp_q.push_back({bh, fin, o});
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_dir   = dir;
    cmd_if.cmd_steps = STEP_W'(steps);
    cmd_if.wrap_en   = wrap;
    @(posedge clk);
    #1 cmd_if.cmd_valid = 1'b0;
    for (int i = 0; i < steps; i++) begin
      @(posedge clk);
      #1 check("step_led", 32'(led), 32'(traj[i]));
    end
    check("busy_in_done", 32'({busy, cmd_if.cmd_ready}), 32'b10);
    @(posedge clk);
    #1 check("ready_after_done", 32'({busy, cmd_if.cmd_ready}), 32'b01);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    rst_n            = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_dir   = 2'b00;
    cmd_if.cmd_steps = '0;
    cmd_if.wrap_en   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_led", 32'(led), 32'h00);
    check("reset_ready_busy", 32'({cmd_if.cmd_ready, busy}), 32'b10);
    check("reset_done_bh", 32'({done, bound_hit}), 32'b00);
    check("reset_odo", 32'(odometer), 32'd0);
    check("reset_state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // +x 3 saturate: x 1,2,3
    run_cmd(2'b00, 3, 1'b0, 1'b0, 8'h01, 8'h02, 8'h03, 8'h03, odo(3));
    // back to origin
    run_cmd(2'b01, 3, 1'b0, 1'b0, 8'h02, 8'h01, 8'h00, 8'h00, odo(6));
    // -x from 0 saturate: blocked twice, busy 3 cycles checked in run_cmd
    run_cmd(2'b01, 2, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, odo(6));
    // -y from 0 wrap: y 15 then 14
    run_cmd(2'b11, 2, 1'b1, 1'b0, 8'hF0, 8'hE0, 8'h00, 8'hE0, odo(8));
    // zero steps: done next cycle, position unchanged
    run_cmd(2'b10, 0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'hE0, odo(8));

    // cmd_valid held through MOVE with a different command
    @(negedge clk);
    exp_q.push_back({1'b1, 8'hF0, odo(9)});
    exp_q.push_back({1'b0, 8'hF2, odo(11)});
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_dir   = 2'b10;
    cmd_if.cmd_steps = 2'd3;
    cmd_if.wrap_en   = 1'b0;
    @(posedge clk);
    #1;
    cmd_if.cmd_dir   = 2'b00;
    cmd_if.cmd_steps = 2'd2;
    cmd_if.wrap_en   = 1'b1;
    cnt = 0;
    while (!cmd_if.cmd_ready && cnt < 20) begin
      @(posedge clk);
      #1 cnt++;
    end
    check("held_first_cycles", 32'(cnt), 32'd4);
    @(posedge clk);
    #1 cmd_if.cmd_valid = 1'b0;
    check("held_second_accept", 32'(busy), 32'd1);
    cnt = 0;
    while (!cmd_if.cmd_ready && cnt < 20) begin
      @(posedge clk);
      #1 cnt++;
    end
    check("held_second_cycles", 32'(cnt), 32'd3);
    repeat (3) @(posedge clk);
    #1 check("idle_after_held", 32'({busy, cmd_if.cmd_ready}), 32'b01);

    // +y wrap from 15 to 0
    run_cmd(2'b10, 1, 1'b1, 1'b0, 8'h02, 8'h00, 8'h00, 8'h02, odo(12));

    // asynchronous reset mid-MOVE at (2,0): no expectation pushed
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_dir   = 2'b00;
    cmd_if.cmd_steps = 2'd3;
    cmd_if.wrap_en   = 1'b0;
    @(posedge clk);
    #1 cmd_if.cmd_valid = 1'b0;
    check("pre_reset_move", 32'({busy, led}), 32'h102);
    #2 rst_n = 1'b0;
    #1;
    check("async_led", 32'(led), 32'h00);
    check("async_ready_busy", 32'({cmd_if.cmd_ready, busy, done}), 32'b100);
    check("async_odo", 32'(odometer), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("post_reset_idle", 32'({busy, cmd_if.cmd_ready, led}), 32'h100);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
